// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared state and owner encodings for mem_arbiter
package mem_arb_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'b000,
      GRANT_I = 3'b001,
      GRANT_D = 3'b010,
      DONE_I  = 3'b101,
      DONE_D  = 3'b110
   } arb_state_e;

   localparam logic OWN_I = 1'b0;
   localparam logic OWN_D = 1'b1;

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// rtl/mem_arbiter_arb_pick.sv - grant selection; MEM_ARB_RR_EN selects round robin
module arb_pick
   import mem_arb_pkg::*;
(
   input  logic i_req,
   input  logic d_req,
   input  logic last_owner,
   output logic grant_valid,
   output logic grant_owner
);

   assign grant_valid = i_req | d_req;

`ifdef MEM_ARB_RR_EN
   // On a tie the client that was not served last goes first.
   always_comb begin
      grant_owner = OWN_I;
      if (i_req && d_req)
         grant_owner = (last_owner == OWN_I) ? OWN_D : OWN_I;
      else if (d_req)
         grant_owner = OWN_D;
   end
`else
   logic unused_last_owner;
   assign unused_last_owner = last_owner;
   assign grant_owner = d_req ? OWN_D : OWN_I;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - serialises icache/dcache block transfers onto one memory port
// MEM_ARB_RR_EN enables round-robin arbitration (default: dcache has priority).
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W  = 6,
   parameter int BLOCK_W = 128
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               i_read,
   input  logic [ADDR_W-1:0]  i_address,
   output logic [BLOCK_W-1:0] i_readdata,
   output logic               i_busywait,
   input  logic               d_read,
   input  logic               d_write,
   input  logic [ADDR_W-1:0]  d_address,
   input  logic [BLOCK_W-1:0] d_writedata,
   output logic [BLOCK_W-1:0] d_readdata,
   output logic               d_busywait,
   output logic               mem_read,
   output logic               mem_write,
   output logic [ADDR_W-1:0]  mem_address,
   output logic [BLOCK_W-1:0] mem_writedata,
   input  logic [BLOCK_W-1:0] mem_readdata,
   input  logic               mem_busywait
);

   arb_state_e         state_q, state_d;
   logic               issued_q, issued_d;
   logic               wr_q, wr_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic [BLOCK_W-1:0] wdata_q, wdata_d;
   logic [BLOCK_W-1:0] i_rdata_q, i_rdata_d;
   logic [BLOCK_W-1:0] d_rdata_q, d_rdata_d;
   logic               i_req, d_req;
   logic               grant_valid, grant_owner, last_owner;

   assign i_req = i_read;
   assign d_req = d_read | d_write;

   arb_pick u_pick (
      .i_req       (i_req),
      .d_req       (d_req),
      .last_owner  (last_owner),
      .grant_valid (grant_valid),
      .grant_owner (grant_owner)
   );

`ifdef MEM_ARB_RR_EN
   logic last_owner_q;
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         last_owner_q <= OWN_I;
      else if (state_q == IDLE && grant_valid)
         last_owner_q <= grant_owner;
   end
   assign last_owner = last_owner_q;
`else
   assign last_owner = OWN_I;
`endif

   always_comb begin
      state_d   = state_q;
      issued_d  = issued_q;
      wr_d      = wr_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      i_rdata_d = i_rdata_q;
      d_rdata_d = d_rdata_q;
      case (state_q)
         IDLE: begin
            issued_d = 1'b0;
            if (grant_valid) begin
               if (grant_owner == OWN_D) begin
                  state_d = GRANT_D;
                  addr_d  = d_address;
                  wr_d    = d_write;
                  wdata_d = d_writedata;
               end else begin
                  state_d = GRANT_I;
                  addr_d  = i_address;
                  wr_d    = 1'b0;
               end
            end
         end
         GRANT_I, GRANT_D: begin
            // Busy is only trusted from the second grant cycle on, so a memory
            // that raises busywait one cycle late cannot fake a completion.
            if (!issued_q) begin
               issued_d = 1'b1;
            end else if (!mem_busywait) begin
               issued_d = 1'b0;
               if (state_q == GRANT_I) begin
                  state_d   = DONE_I;
                  i_rdata_d = mem_readdata;
               end else begin
                  state_d = DONE_D;
                  if (!wr_q)
                     d_rdata_d = mem_readdata;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         issued_q  <= 1'b0;
         wr_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         i_rdata_q <= '0;
         d_rdata_q <= '0;
      end else begin
         state_q   <= state_d;
         issued_q  <= issued_d;
         wr_q      <= wr_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         i_rdata_q <= i_rdata_d;
         d_rdata_q <= d_rdata_d;
      end
   end

   assign mem_read      = (state_q == GRANT_I) || (state_q == GRANT_D && !wr_q);
   assign mem_write     = (state_q == GRANT_D) && wr_q;
   assign mem_address   = addr_q;
   assign mem_writedata = wdata_q;
   assign i_readdata    = i_rdata_q;
   assign d_readdata    = d_rdata_q;
   assign i_busywait    = i_req && (state_q != DONE_I);
   assign d_busywait    = d_req && (state_q != DONE_D);

endmodule
